modmult_arbiter: RTL and testbench
==================================

Name: modmult_arbiter

Overview:
- Shares one pipelined ModMult instance between NUM_REQ requesters, for example NTT butterfly lanes and a twiddle generator.
- Arbitrates round-robin, registers the winning operands into the multiplier, and carries a requester tag alongside the multiplier pipeline.
- Returns each result with its requester ID, in issue order.
- Owns the shared modulus register q. A q update is sequenced by draining the pipeline first.

Parameters:
- DATA_SIZE, `DATA_SIZE_ARB: operand, modulus and result width.
- NUM_REQ, 4: number of requesters, 2..8.
- MULT_LATENCY, 4: fixed ModMult latency in cycles from registered A/B/q to valid C.
- ID_W, $clog2(NUM_REQ): requester tag width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant; a handshake is req_valid[i] & req_ready[i].
- req_a  in  NUM_REQ*DATA_SIZE  flattened A operands; requester i is at [i*DATA_SIZE +: DATA_SIZE].
- req_b  in  NUM_REQ*DATA_SIZE  flattened B operands, same packing.
- cfg_q_valid  in  1  request to load a new modulus.
- cfg_q  in  DATA_SIZE  new modulus value.
- cfg_q_ready  out  1  pulses for one cycle when cfg_q is loaded.
- res_valid  out  1  result valid, single-cycle pulse, no backpressure.
- res_id  out  ID_W  requester that issued the result.
- res_data  out  DATA_SIZE  (A*B) mod q.
- res_err  out  1  operand range error; driven only when MODMULT_ARB_RANGECHK_EN is defined, otherwise tied 0.
- busy  out  1  high while any operation is in flight or the state is not S_RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - outputs: req_ready=0, res_valid=0, res_id=0, res_data=0, res_err=0, cfg_q_ready=0.
  - internal: q register=0, round-robin pointer=NUM_REQ-1, tag pipe cleared, state=S_IDLE.
- Reset asserted mid-operation: all in-flight operations are discarded and no res_valid is produced for them.
- State machine:
  - S_IDLE: q is not yet valid and no grants are given. On cfg_q_valid go to S_LOAD.
  - S_RUN: grants are given.
    - On cfg_q_valid, stop granting in the same cycle and go to S_DRAIN.
    - If the tag pipe is already empty, go straight to S_LOAD.
  - S_DRAIN: no grants. Stay here until the tag pipe holds no valid entries, then go to S_LOAD.
  - S_LOAD: load q from cfg_q, pulse cfg_q_ready for one cycle, then go to S_RUN.
- Arbitration (S_RUN only):
  - req_ready is combinational from req_valid and the state.
  - The grant goes to the first requester with req_valid set, searching upward from pointer+1 and wrapping around.
  - On a handshake the pointer takes the granted index.
  - At most one grant per cycle; req_ready is all-zero when no requester is valid.
  - Requester i holding req_valid is granted within NUM_REQ cycles. A requester may change its operands only after its handshake.
- Issue:
  - At the handshake edge, A/B are registered into the ModMult inputs.
  - At the same edge, {valid=1, id, err} enters the tag shift register. Its depth is MULT_LATENCY, with stage 0 at that edge.
  - In cycles with no grant, a bubble (valid=0) shifts in.
- Result timing:
  - A handshake at edge t gives res_valid=1 during the cycle after edge t+MULT_LATENCY+1.
  - res_id, res_data and res_err are registered together with res_valid.
  - Back-to-back issue gives one result per cycle; order is preserved.
- Arithmetic:
  - Operands are unsigned DATA_SIZE bits.
  - The result equals ModMult C, which is (A*B) mod q for A,B < q.
- Simultaneous events:
  - cfg_q_valid together with req_valid in S_RUN: the config wins and no grant is given that cycle.
  - cfg_q_valid held high: the block completes exactly one load per rising cfg_q_ready.
- busy is 0 only in S_RUN with an empty tag pipe.

Optional Feature:
- Macro: MODMULT_ARB_RANGECHK_EN.
- Defined:
  - A handshake whose A>=q or B>=q is still accepted and tagged err=1.
  - Zero operands are issued instead of the requester's A/B.
  - The result slot returns res_err=1, res_data=0 at the normal latency, keeping ordering.
- Undefined: no comparators are built, res_err is held 0, and out-of-range operands pass to ModMult unchecked.

Test Plan:
- Reset, cfg_q=4244570881, one request (req 2, A=5953, B=1229): cfg_q_ready pulses once. Result is res_valid with res_id=2 and res_data=7316237, MULT_LATENCY+1 cycles after the handshake.
- Requests 0..3 all held valid for 8 cycles, q=4244570881: the grant order is 0,1,2,3,0,1,2,3. Eight results come back on consecutive cycles with matching IDs.
- A=B=4244570880, q=4244570881: res_data=1.
- cfg_q_valid asserted while 3 operations are in flight: no grants are given until their 3 results return. cfg_q_ready then pulses, and the next result uses the new q.
- Reset deasserted→asserted with 2 operations in flight: no res_valid follows. After release and reload of q, normal operation resumes with pointer=NUM_REQ-1, so req 0 wins first.
- With MODMULT_ARB_RANGECHK_EN defined, q=97, A=100, B=3 from req 1: res_err=1, res_data=0, res_id=1. A following A=96, B=96 request gives res_data=1 with res_err=0.

Source files
------------

// File: rtl/modmult_arbiter.sv
// Round-robin sharing of one pipelined ModMult between NUM_REQ requesters, returning tagged results in issue order.
// Modulus updates drain the pipe first. Define MODMULT_ARB_RANGECHK_EN to tag out-of-range operands as errors.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

module modmult_arb_mm #(
  parameter int W   = 32,
  parameter int LAT = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] c_o
);
  logic [2*W-1:0] prod_q;
  logic [2*W-1:0] q_ext;
  logic [W-1:0]   stg_q [LAT-1];

  assign q_ext = {{W{1'b0}}, q_i};

  // Stage 1 multiplies, stage 2 reduces, remaining stages only pad out to LAT (LAT >= 2).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
      for (int i = 0; i < LAT-1; i++) stg_q[i] <= '0;
    end else begin
      prod_q   <= {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
      stg_q[0] <= (q_i == '0) ? '0 : W'(prod_q % q_ext);
      for (int i = 1; i < LAT-1; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign c_o = stg_q[LAT-2];
endmodule

module modmult_arbiter #(
  parameter int DATA_SIZE    = `DATA_SIZE_ARB,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 4,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_a,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_b,
  input  logic                         cfg_q_valid,
  input  logic [DATA_SIZE-1:0]         cfg_q,
  output logic                         cfg_q_ready,
  output logic                         res_valid,
  output logic [ID_W-1:0]              res_id,
  output logic [DATA_SIZE-1:0]         res_data,
  output logic                         res_err,
  output logic                         busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_LOAD} state_t;

  state_t                  state_q;
  logic [DATA_SIZE-1:0]    q_q;
  logic                    cfg_q_ready_q;
  logic [ID_W-1:0]         ptr_q;
  logic [DATA_SIZE-1:0]    op_a [NUM_REQ];
  logic [DATA_SIZE-1:0]    op_b [NUM_REQ];
  logic                    gnt_any;
  logic [ID_W-1:0]         gnt_idx;
  logic [ID_W-1:0]         cand;
  logic                    err_d;
  logic [DATA_SIZE-1:0]    a_d, b_d;
  logic [DATA_SIZE-1:0]    a_q, b_q;
  logic [DATA_SIZE-1:0]    mm_c;
  logic [MULT_LATENCY-1:0] tag_vld_q;
  logic [MULT_LATENCY-1:0] tag_err_q;
  logic [ID_W-1:0]         tag_id_q [MULT_LATENCY];
  logic                    al_vld_q, al_err_q;
  logic [ID_W-1:0]         al_id_q;
  logic                    res_valid_q, res_err_q;
  logic [ID_W-1:0]         res_id_q;
  logic [DATA_SIZE-1:0]    res_data_q;
  logic                    inflight;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[gi*DATA_SIZE +: DATA_SIZE];
      assign op_b[gi] = req_b[gi*DATA_SIZE +: DATA_SIZE];
    end
  endgenerate

  // A pending modulus update blocks grants in the very cycle it is seen.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    if (state_q == S_RUN && !cfg_q_valid) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        cand = ID_W'((int'(ptr_q) + off) % NUM_REQ);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end
  end

`ifdef MODMULT_ARB_RANGECHK_EN
  assign err_d = (op_a[gnt_idx] >= q_q) || (op_b[gnt_idx] >= q_q);
`else
  assign err_d = 1'b0;
`endif
  assign a_d = err_d ? '0 : op_a[gnt_idx];
  assign b_d = err_d ? '0 : op_b[gnt_idx];

  // The alignment stage covers the cycle between the last tag stage and C becoming valid.
  assign inflight = (|tag_vld_q) | al_vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      q_q           <= '0;
      cfg_q_ready_q <= 1'b0;
    end else begin
      cfg_q_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_q_valid) begin
            state_q       <= S_LOAD;
            cfg_q_ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (cfg_q_valid) begin
            if (inflight) begin
              state_q <= S_DRAIN;
            end else begin
              state_q       <= S_LOAD;
              cfg_q_ready_q <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!inflight) begin
            state_q       <= S_LOAD;
            cfg_q_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          q_q     <= cfg_q;
          state_q <= S_RUN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= ID_W'(NUM_REQ-1);
      a_q         <= '0;
      b_q         <= '0;
      tag_vld_q   <= '0;
      tag_err_q   <= '0;
      for (int i = 0; i < MULT_LATENCY; i++) tag_id_q[i] <= '0;
      al_vld_q    <= 1'b0;
      al_err_q    <= 1'b0;
      al_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      if (gnt_any) begin
        ptr_q <= gnt_idx;
        a_q   <= a_d;
        b_q   <= b_d;
      end
      tag_vld_q   <= {tag_vld_q[MULT_LATENCY-2:0], gnt_any};
      tag_err_q   <= {tag_err_q[MULT_LATENCY-2:0], gnt_any & err_d};
      tag_id_q[0] <= gnt_idx;
      for (int i = 1; i < MULT_LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
      al_vld_q    <= tag_vld_q[MULT_LATENCY-1];
      al_err_q    <= tag_err_q[MULT_LATENCY-1];
      al_id_q     <= tag_id_q[MULT_LATENCY-1];
      res_valid_q <= al_vld_q;
      if (al_vld_q) begin
        res_id_q   <= al_id_q;
        res_data_q <= al_err_q ? '0 : mm_c;
        res_err_q  <= al_err_q;
      end
    end
  end

  modmult_arb_mm #(
    .W   (DATA_SIZE),
    .LAT (MULT_LATENCY)
  ) u_mm (
    .clk_i  (clk),
    .rst_ni (reset),
    .a_i    (a_q),
    .b_i    (b_q),
    .q_i    (q_q),
    .c_o    (mm_c)
  );

  assign cfg_q_ready = cfg_q_ready_q;
  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;
  assign busy        = (state_q != S_RUN) | inflight;
endmodule

// File: tb/tb_modmult_arbiter.sv
// Scoreboard bench for modmult_arbiter: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_modmult_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 4;
  localparam int IDW = 2;
  localparam logic [W-1:0] Q1 = 32'd4244570881;

  typedef struct {
    int           id;
    logic [W-1:0] data;
    logic         err;
    longint       cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           cfg_q_valid;
  logic [W-1:0]   cfg_q;
  logic           cfg_q_ready, res_valid, res_err, busy;
  logic [IDW-1:0] res_id;
  logic [W-1:0]   res_data;

  logic [W-1:0] a_v [N];
  logic [W-1:0] b_v [N];
  logic [W-1:0] e_v [N];
  logic         er_v [N];

  exp_t   exp_q[$];
  exp_t   mon_e;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     res_cnt = 0;
  int     base;

  modmult_arbiter #(
    .DATA_SIZE    (W),
    .NUM_REQ      (N),
    .MULT_LATENCY (L),
    .ID_W         (IDW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .cfg_q_valid (cfg_q_valid),
    .cfg_q       (cfg_q),
    .cfg_q_ready (cfg_q_ready),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res_data    (res_data),
    .res_err     (res_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset && res_valid) begin
      res_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got id=%0d data=%0d, required no result (cycle %0d)", res_id, res_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_id", 64'(res_id), 64'(mon_e.id));
        chk("res_data", 64'(res_data), 64'(mon_e.data));
        chk("res_err", 64'(res_err), 64'(mon_e.err));
        chk("res_cycle", 64'(cyc), 64'(mon_e.cyc));
        $display("result id=%0d data=%0d err=%0d cycle=%0d", res_id, res_data, res_err, cyc);
      end
    end
  end

  task automatic drive(input logic [N-1:0] vmask);
    req_valid = vmask;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_v[i];
      req_b[i*W +: W] = b_v[i];
    end
  endtask

  // Called just after a falling edge; the following rising edge is the handshake.
  task automatic present(input logic [N-1:0] vmask, input int gnt);
    logic [N-1:0] exp_g;
    exp_g = '0;
    drive(vmask);
    #1;
    if (gnt >= 0) exp_g[gnt] = 1'b1;
    chk("grant", 64'(req_ready), 64'(exp_g));
    if (gnt >= 0) begin
      exp_q.push_back('{gnt, e_v[gnt], er_v[gnt], cyc + L + 2});
      $display("issue req=%0d a=%0d b=%0d expect=%0d", gnt, a_v[gnt], b_v[gnt], e_v[gnt]);
    end
  endtask

  task automatic step(input logic [N-1:0] vmask, input int gnt);
    @(negedge clk);
    present(vmask, gnt);
  endtask

  task automatic load_q(input logic [W-1:0] v, input logic [N-1:0] vmask);
    bit seen;
    seen = 0;
    @(negedge clk);
    drive(vmask);
    cfg_q_valid = 1'b1;
    cfg_q       = v;
    for (int i = 0; i < 60 && !seen; i++) begin
      #1;
      chk("cfg_blocks_grant", 64'(req_ready), 64'(0));
      if (cfg_q_ready) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL cfg_q_ready_timeout: got no pulse, required one pulse");
    end
    @(posedge clk);
    #1;
    cfg_q_valid = 1'b0;
    @(negedge clk);
    chk("cfg_ready_single_pulse", 64'(cfg_q_ready), 64'(0));
    chk("busy_after_load", 64'(busy), 64'(0));
    $display("load q=%0d", v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive('0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_id", 64'(res_id), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_res_err", 64'(res_err), 64'(0));
    chk("rst_cfg_ready", 64'(cfg_q_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: got %0d results missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    cfg_q_valid = 1'b0;
    cfg_q       = '0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0; b_v[i] = '0; e_v[i] = '0; er_v[i] = 1'b0;
    end
    do_reset();

    // Idle: modulus not loaded, nothing may be granted.
    @(negedge clk);
    drive(4'b1111);
    #1;
    chk("idle_no_grant", 64'(req_ready), 64'(0));
    chk("idle_busy", 64'(busy), 64'(1));
    load_q(Q1, 4'b0000);

    a_v[2] = 32'd5953; b_v[2] = 32'd1229; e_v[2] = 32'd7316237;
    step(4'b0100, 2);
    step(4'b0000, -1);
    a_v[0] = Q1 - 1; b_v[0] = Q1 - 1; e_v[0] = 32'd1;
    step(4'b0001, 0);
    step(4'b0000, -1);
    wait_empty();

    // Round-robin from a fresh pointer, then a sparse mask to exercise wrap-around.
    do_reset();
    load_q(Q1, 4'b0000);
    for (int i = 0; i < N; i++) begin
      a_v[i] = 32'(1000 + i); b_v[i] = 32'd3; e_v[i] = 32'(3000 + 3*i);
    end
    for (int k = 0; k < 8; k++) step(4'b1111, k % N);
    step(4'b1010, 1);
    step(4'b1010, 3);
    step(4'b1010, 1);
    step(4'b0000, -1);
    wait_empty();

    // Modulus change with three operations in flight and a competing request.
    step(4'b0001, 0);
    step(4'b0010, 1);
    step(4'b0100, 2);
    base = res_cnt;
    a_v[3] = 32'd96; b_v[3] = 32'd96; e_v[3] = 32'd1;
    load_q(32'd97, 4'b1000);
    chk("drained_before_load", 64'(res_cnt - base), 64'(3));
    present(4'b1000, 3);
    step(4'b0000, -1);
    wait_empty();

    // Out-of-range operands against q=97.
    a_v[1] = 32'd100; b_v[1] = 32'd3;
`ifdef MODMULT_ARB_RANGECHK_EN
    e_v[1] = 32'd0; er_v[1] = 1'b1;
`else
    e_v[1] = 32'd9; er_v[1] = 1'b0;
`endif
    step(4'b0010, 1);
    a_v[1] = 32'd96; b_v[1] = 32'd96; e_v[1] = 32'd1; er_v[1] = 1'b0;
    step(4'b0010, 1);
    step(4'b0000, -1);
    wait_empty();

    // Reset with two operations in flight: they must vanish.
    step(4'b0001, 0);
    step(4'b0010, 1);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_res_after_reset", 64'(res_valid), 64'(0));
    end
    chk("busy_idle_after_reset", 64'(busy), 64'(1));
    load_q(Q1, 4'b0000);
    step(4'b1111, 0);
    step(4'b0000, -1);
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
